// File: rtl/io_hub.sv
// io_hub: I/O port responder with 2-deep input FIFOs and registered output channels
module io_hub #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  localparam int AIN = NUIOIN > 1 ? $clog2(NUIOIN) : 1,
  localparam int AOU = NUIOOU > 1 ? $clog2(NUIOOU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_in,
  input  logic [AIN-1:0]           addr_in,
  output logic [NUBITS-1:0]        io_in,
  input  logic                     out_en,
  input  logic [AOU-1:0]           addr_out,
  input  logic [NUBITS-1:0]        data_out,
  input  logic [NUIOIN-1:0]        in_valid,
  output logic [NUIOIN-1:0]        in_ready,
  input  logic [NUIOIN*NUBITS-1:0] in_data,
  output logic [NUIOIN-1:0]        in_avail,
  output logic [NUIOOU-1:0]        ou_valid,
  input  logic [NUIOOU-1:0]        ou_ready,
  output logic [NUIOOU*NUBITS-1:0] ou_data,
  input  logic                     err_clr,
  output logic [2:0]               err
);
  logic [NUIOIN-1:0] sel_in, und;
  logic [NUIOOU-1:0] sel_ou, ovr;
  logic [NUBITS-1:0] val [NUIOIN];
  logic [2:0] err_q, err_d;
  for (genvar i = 0; i < NUIOIN; i++) begin : g_in
    logic [NUBITS-1:0] m_q [2];
    logic [NUBITS-1:0] hold_q, head;
    logic [1:0] cnt_q, cnt_d;
    logic hd_q, tl_q, push, pop;
    assign sel_in[i] = addr_in == AIN'(i);
    assign in_ready[i] = (cnt_q != 2'd2) & ~rst;
    assign in_avail[i] = cnt_q != 2'd0;
    assign head = m_q[hd_q];
    assign push = in_valid[i] & in_ready[i];
    assign pop = req_in & sel_in[i] & in_avail[i];
    assign und[i] = req_in & sel_in[i] & ~in_avail[i];
    assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    assign val[i] = in_avail[i] ? head : hold_q;
    // FIFO storage, pointers and last-popped value for this input channel
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= 2'd0;
        hd_q <= 1'b0;
        tl_q <= 1'b0;
        hold_q <= '0;
        m_q[0] <= '0;
        m_q[1] <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (push) begin
          m_q[tl_q] <= in_data[i*NUBITS +: NUBITS];
          tl_q <= ~tl_q;
        end
        if (pop) begin
          hold_q <= head;
          hd_q <= ~hd_q;
        end
      end
    end
  end
  for (genvar j = 0; j < NUIOOU; j++) begin : g_ou
    logic [NUBITS-1:0] od_q;
    logic ov_q, wr;
    assign sel_ou[j] = addr_out == AOU'(j);
    assign wr = out_en & sel_ou[j];
    assign ovr[j] = wr & ov_q & ~ou_ready[j];
    assign ou_valid[j] = ov_q;
    assign ou_data[j*NUBITS +: NUBITS] = od_q;
    // a same-cycle write keeps the channel valid even while it is being consumed
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ov_q <= 1'b0;
        od_q <= '0;
      end else begin
        ov_q <= wr | (ov_q & ~ou_ready[j]);
        if (wr) od_q <= data_out;
      end
    end
  end
  // an unmatched address selects no channel, so the mux returns zero
  always_comb begin
    io_in = '0;
    for (int k = 0; k < NUIOIN; k++) io_in = io_in | (sel_in[k] ? val[k] : '0);
  end
  assign err_d = (err_clr ? 3'b000 : err_q) | {(req_in & ~|sel_in) | (out_en & ~|sel_ou), |ovr, |und};
  assign err = err_q;
  // sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 3'b000;
    else err_q <= err_d;
  end
endmodule

// File: tb/tb_io_hub.sv
// tb_io_hub: directed and randomised checks of io_hub against a queue-based model
module tb_io_hub;
  localparam int NI = 6, NO = 6, W = 32;
  logic clk = 0, rst = 1, req_in = 0, out_en = 0, err_clr = 0;
  logic [2:0] addr_in = 0, addr_out = 0;
  logic [W-1:0] data_out = 0, io_in;
  logic [NI-1:0] in_valid = 0, in_ready, in_avail;
  logic [NI*W-1:0] in_data = 0;
  logic [NO-1:0] ou_valid, ou_ready = 0;
  logic [NO*W-1:0] ou_data;
  logic [2:0] err;
  int n_chk = 0, n_fail = 0;

  io_hub #(.NUBITS(W), .NUIOIN(NI), .NUIOOU(NO)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_avail(in_avail),
    .ou_valid(ou_valid), .ou_ready(ou_ready), .ou_data(ou_data),
    .err_clr(err_clr), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: each input channel is a queue of at most two words plus a hold word.
  logic [W-1:0] mq [NI][$];
  logic [W-1:0] mh [NI];
  logic [W-1:0] mod [NO];
  logic [NO-1:0] mov;
  logic [2:0] merr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        mq[i].delete();
        mh[i] = 0;
      end
      for (int j = 0; j < NO; j++) mod[j] = 0;
      mov = 0;
      merr = 0;
    end else begin
      logic [2:0] ev;
      logic [NI-1:0] pv;
      int a;
      ev = 0;
      for (int i = 0; i < NI; i++) pv[i] = in_valid[i] && mq[i].size() < 2;
      if (req_in) begin
        a = int'(addr_in);
        if (a >= NI) ev[2] = 1;
        else if (mq[a].size() == 0) ev[0] = 1;
        else mh[a] = mq[a].pop_front();
      end
      for (int i = 0; i < NI; i++) if (pv[i]) mq[i].push_back(in_data[i*W +: W]);
      if (out_en) begin
        a = int'(addr_out);
        if (a >= NO) ev[2] = 1;
        else if (mov[a] && !ou_ready[a]) ev[1] = 1;
      end
      for (int j = 0; j < NO; j++) begin
        if (out_en && int'(addr_out) == j) begin
          mov[j] = 1;
          mod[j] = data_out;
        end else if (ou_ready[j]) mov[j] = 0;
      end
      merr = (err_clr ? 3'b000 : merr) | ev;
    end
  end

  // Compare every cycle, mid-way between active edges.
  always @(negedge clk) begin
    logic [NI-1:0] er, ea;
    logic [NO*W-1:0] ed;
    logic [W-1:0] ei;
    int a;
    for (int i = 0; i < NI; i++) begin
      er[i] = mq[i].size() < 2 && !rst;
      ea[i] = mq[i].size() > 0;
    end
    for (int j = 0; j < NO; j++) ed[j*W +: W] = mod[j];
    a = int'(addr_in);
    ei = a >= NI ? 0 : (mq[a].size() > 0 ? mq[a][0] : mh[a]);
    chk("m_in_ready", in_ready, er);
    chk("m_in_avail", in_avail, ea);
    chk("m_io_in", io_in, ei);
    chk("m_ou_valid", ou_valid, mov);
    chk("m_ou_data", ou_data, ed);
    chk("m_err", err, merr);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_io_in", io_in, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err", err, 0);
    rst = 0;
    #1 chk("rel_in_ready", in_ready, 6'h3f);
    // two pushes fill channel 3
    cyc();
    in_valid[3] = 1; in_data[3*W +: W] = 32'h11;
    cyc();
    in_data[3*W +: W] = 32'h22;
    cyc();
    in_valid = 0;
    chk("ch3_full", in_ready[3], 0);
    req_in = 1; addr_in = 3;
    #1 chk("ch3_head", io_in, 32'h11);
    cyc();
    req_in = 0;
    chk("ch3_next", io_in, 32'h22);
    req_in = 1;
    cyc();
    req_in = 0;
    chk("ch3_empty", in_avail[3], 0);
    chk("ch3_hold", io_in, 32'h22);
    // empty read then clear
    req_in = 1; addr_in = 5;
    #1 chk("ch5_rd", io_in, 0);
    cyc();
    req_in = 0;
    chk("und_err", err, 3'b001);
    err_clr = 1;
    cyc();
    err_clr = 0;
    chk("err_clr", err, 0);
    // simultaneous push and pop at count 1
    in_valid[0] = 1; in_data[0 +: W] = 32'hA;
    cyc();
    in_data[0 +: W] = 32'hB; req_in = 1; addr_in = 0;
    #1 chk("ch0_a", io_in, 32'hA);
    cyc();
    in_valid = 0; req_in = 0;
    chk("ch0_b", io_in, 32'hB);
    chk("ch0_rdy", in_ready[0], 1);
    chk("ch0_avail", in_avail[0], 1);
    // overrun on output channel 2
    out_en = 1; addr_out = 2; data_out = 32'hDEAD;
    cyc();
    data_out = 32'hBEEF;
    cyc();
    out_en = 0;
    chk("ou2_data", ou_data[2*W +: W], 32'hBEEF);
    chk("ovr_err", err[1], 1);
    ou_ready[2] = 1;
    cyc();
    ou_ready[2] = 0;
    chk("ou2_cons", ou_valid[2], 0);
    err_clr = 1;
    cyc();
    err_clr = 0;
    // write while consuming channel 1
    out_en = 1; addr_out = 1; data_out = 32'h7;
    cyc();
    ou_ready[1] = 1; data_out = 32'h5;
    cyc();
    out_en = 0;
    chk("ou1_valid", ou_valid[1], 1);
    chk("ou1_data", ou_data[W +: W], 32'h5);
    chk("ou1_noovr", err[1], 0);
    cyc();
    ou_ready = 0;
    chk("ou1_cons", ou_valid[1], 0);
    // bad addresses
    req_in = 1; addr_in = 7;
    #1 chk("bad_io_in", io_in, 0);
    cyc();
    req_in = 0;
    chk("bad_err", err[2], 1);
    chk("bad_nopop", in_avail[0], 1);
    err_clr = 1;
    cyc();
    err_clr = 0; out_en = 1; addr_out = 6; data_out = 32'h99;
    cyc();
    out_en = 0;
    chk("bad_out_err", err, 3'b100);
    // randomised traffic
    for (int n = 0; n < 300; n++) begin
      in_valid = NI'($urandom);
      for (int i = 0; i < NI; i++) in_data[i*W +: W] = $urandom;
      req_in = $urandom_range(0, 1);
      addr_in = 3'($urandom_range(0, 7));
      out_en = $urandom_range(0, 1);
      addr_out = 3'($urandom_range(0, 7));
      data_out = $urandom;
      ou_ready = NO'($urandom);
      err_clr = $urandom_range(0, 7) == 0;
      cyc();
    end
    // asynchronous reset mid-stream
    in_valid = 6'h3f; req_in = 0; out_en = 1; addr_out = 0; data_out = 32'h1234; ou_ready = 0;
    cyc();
    addr_in = 0;
    #2 rst = 1;
    #1;
    chk("ar_io_in", io_in, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_in_avail", in_avail, 0);
    chk("ar_ou_valid", ou_valid, 0);
    chk("ar_ou_data", ou_data, 0);
    chk("ar_err", err, 0);
    in_valid = 0; out_en = 0;
    cyc();
    rst = 0;
    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/io_hub.md
# io_hub

Peripheral-side responder for the processor core's I/O port bus. It accepts external samples on NUIOIN valid/ready input channels and buffers each in a 2-entry FIFO, returning the head of the addressed FIFO to the core on each input request. It captures core output writes into NUIOOU registered valid/ready output channels. It sits between a processor core instance and the surrounding datapath, one hub per core, and makes both sides of the core's IN/OUT instructions flow-controlled.

## Interface

- NUBITS, 32, data width of the core and of every channel
- NUIOIN, 8, number of input channels (≥1)
- NUIOOU, 8, number of output channels (≥1)
- AIN = max(1, $clog2(NUIOIN)), derived, input address width
- AOU = max(1, $clog2(NUIOOU)), derived, output address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_in  in  1  core input request, one-cycle strobe
- addr_in  in  AIN  input channel selected by the core
- io_in  out  NUBITS  data returned to the core
- out_en  in  1  core output write strobe
- addr_out  in  AOU  output channel selected by the core
- data_out  in  NUBITS  core write data
- in_valid  in  NUIOIN  external producer valid, one bit per channel
- in_ready  out  NUIOIN  hub can accept, one bit per channel
- in_data  in  NUIOIN*NUBITS  flattened producer data; channel i is bits [i*NUBITS +: NUBITS]
- in_avail  out  NUIOIN  channel FIFO non-empty
- ou_valid  out  NUIOOU  output register holds unconsumed data
- ou_ready  in  NUIOOU  external consumer ready
- ou_data  out  NUIOOU*NUBITS  flattened output registers
- err_clr  in  1  clears the sticky error flags
- err  out  3  sticky flags: [0] underflow, [1] overrun, [2] bad address

## Operation

- Input FIFO per channel: depth 2, count register 0..2, head/tail pointers 1 bit each; in_ready[i] = (count<2) & ~rst.
- Push: in_valid[i] & in_ready[i] writes in_data slice i at the tail, count+1.
- Read: io_in is combinational. It is the head of FIFO[addr_in] when in_avail[addr_in]=1; otherwise it is hold[addr_in], the last value popped from that channel.
- Pop: on req_in with a valid address and a non-empty FIFO, pop the head and copy it to hold[addr_in].
- Empty read: req_in to an empty FIFO means no pop, io_in = hold value, err[0] set.
- Bad address (addr_in ≥ NUIOIN or addr_out ≥ NUIOOU, only possible for non-power-of-2 sizes): io_in = 0, no pop or write, err[2] set.
- Push and pop in the same cycle on one channel: both take effect. Count is unchanged at count=1 and becomes 1 at count=2. At count=0 the push occurs, the pop is an empty read (err[0]), and the FIFO ends with count=1. There is no pass-through.
- Output write: out_en writes data_out into ou_data slice addr_out and sets ou_valid[addr_out].
- Consume: ou_valid[j] & ou_ready[j] clears ou_valid[j] unless channel j is written in the same cycle. A write in the same cycle keeps valid=1 with the new data and is not an overrun.
- Overrun: out_en to channel j with ou_valid[j]=1 and ou_ready[j]=0 overwrites the data and sets err[1].
- Errors: err bits are sticky until err_clr. If err_clr coincides with a new error event, the set wins.
- Simultaneous req_in and out_en are independent and both are honoured.

## Timing

- Reset values: io_in = 0 (hold registers = 0, FIFOs empty), in_ready = 0 while rst=1 and all 1 from the first cycle after release, in_avail = 0, ou_valid = 0, ou_data = 0, err = 0.
- Reset asserted mid-operation: all FIFO contents and pending output data are discarded immediately (asynchronous).
- Input latency: data pushed at edge k makes in_avail=1 and is presented on io_in after edge k, so it is readable by a req_in in cycle k+1.
- Pop takes effect at the edge where req_in=1. io_in shows the next entry, or the hold value, after that edge.
- Output latency: out_en at edge k gives ou_valid=1 and new ou_data after edge k. The earliest consume is edge k+1.
- Throughput: one push per input channel per cycle, one core read per cycle, one core write per cycle.
- req_in and out_en are single-cycle strobes. A strobe held for n cycles counts as n events.

## Test plan

- Reset then push 0x11 and 0x22 on channel 3 → in_ready[3]=0 after the second push. req_in addr 3 → io_in = 0x11 before the edge and 0x22 after it. A second req_in → in_avail[3]=0 and io_in holds 0x22.
- Read empty channel 5 after reset → io_in = 0, err = 3'b001. Assert err_clr → err = 0.
- Channel 0 with count=1 (0xA): push 0xB together with req_in → io_in = 0xA that cycle, then 0xB, count stays 1, in_ready[0]=1.
- out_en addr 2 data 0xDEAD with ou_ready[2]=0, then out_en addr 2 data 0xBEEF → ou_data slice 2 = 0xBEEF, err[1]=1. Raise ou_ready[2] → ou_valid[2]=0 the next cycle.
- ou_valid[1]=1 with ou_ready[1]=1 and out_en addr 1 data 0x5 in the same cycle → ou_valid[1] stays 1, data 0x5, err[1]=0.
- NUIOIN=6: req_in addr 7 → io_in = 0, err[2]=1, no FIFO change. Assert rst mid-stream → all outputs return to their reset values within the same cycle.
